// File: rtl/clock_phase_decoder.sv
// Receive-side phase decoder for one divider channel: synchronizes P/Q/R, checks the
// legal phase sequence, tracks lock and regenerates phase/bit/syllable strobes.
module clock_phase_decoder #(
  parameter int BITS_PER_SYL = 14,
  parameter int LOCK_COUNT   = 4,
  parameter int SYNC_STAGES  = 2,
  parameter int TIMEOUT      = 64
) (
  input  logic       CLK,
  input  logic       RSTN,
  input  logic       PI,
  input  logic       QI,
  input  logic       RI,
  input  logic       ERR_CLR,
  output logic [1:0] PHASE,
  output logic       PHASE_STB,
  output logic [3:0] BIT_TIME,
  output logic       BIT_STB,
  output logic       SYL_STB,
  output logic       LOCKED,
  output logic       SEQ_ERR,
  output logic [7:0] ERR_CNT
);

  typedef enum logic [1:0] {
    ST_HUNT   = 2'd0,
    ST_VERIFY = 2'd1,
    ST_LOCKED = 2'd2
  } state_t;

  function automatic logic [1:0] decode(input logic p, input logic q);
    logic [1:0] ph;
    case ({p, q})
      2'b00:   ph = 2'd0;
      2'b10:   ph = 2'd1;
      2'b11:   ph = 2'd2;
      default: ph = 2'd3;
    endcase
    return ph;
  endfunction

  // Bit 2 = P, bit 1 = Q, bit 0 = R throughout.
  logic [2:0] raw_s;
  logic [2:0] sync_s;
  assign raw_s = {PI, QI, RI};

  genvar gi;
  generate
    for (gi = 0; gi < 3; gi++) begin : g_sync
      logic [SYNC_STAGES-1:0] chain_q;
      always_ff @(posedge CLK or negedge RSTN) begin
        if (!RSTN) begin
          chain_q <= '0;
        end else begin
          chain_q <= {chain_q[SYNC_STAGES-2:0], raw_s[gi]};
        end
      end
      assign sync_s[gi] = chain_q[SYNC_STAGES-1];
    end
  endgenerate

  state_t     state_q, state_d;
  logic [1:0] prime_cnt_q, prime_cnt_d;
  logic       primed_q, primed_d;
  logic       ref_valid_q, ref_valid_d;
  logic [2:0] ref_q, ref_d;
  logic [7:0] stall_cnt_q, stall_cnt_d;
  logic [3:0] step_cnt_q, step_cnt_d;
  logic [3:0] bit_time_q, bit_time_d;
  logic [1:0] phase_q, phase_d;
  logic       phase_stb_q, phase_stb_d;
  logic       bit_stb_q, bit_stb_d;
  logic       syl_stb_q, syl_stb_d;
  logic       seq_err_q, seq_err_d;
  logic [7:0] err_cnt_q, err_cnt_d;

  logic [1:0] cur_ph, ref_ph;
  logic       chg, legal, illegal, stall, wrap_step;

  assign cur_ph    = decode(sync_s[2], sync_s[1]);
  assign ref_ph    = decode(ref_q[2], ref_q[1]);
  assign chg       = ref_valid_q && (sync_s != ref_q);
  assign wrap_step = (ref_ph == 2'd3);
  // R must toggle exactly on the 3->0 step and stay put on every other step.
  assign legal     = chg && (cur_ph == ref_ph + 2'd1) && ((sync_s[0] != ref_q[0]) == wrap_step);
  assign illegal   = chg && !legal;
  assign stall     = ref_valid_q && !chg && (stall_cnt_q == 8'(TIMEOUT - 1));

  // Priming: wait for the synchronizer to fill, then take one sample as the reference.
  always_comb begin
    prime_cnt_d = prime_cnt_q;
    primed_d    = primed_q;
    ref_valid_d = ref_valid_q;
    ref_d       = ref_q;
    stall_cnt_d = stall_cnt_q;
    if (!primed_q) begin
      if (prime_cnt_q == 2'(SYNC_STAGES - 1)) begin
        primed_d = 1'b1;
      end else begin
        prime_cnt_d = prime_cnt_q + 2'd1;
      end
    end else if (!ref_valid_q) begin
      ref_valid_d = 1'b1;
      ref_d       = sync_s;
    end else if (chg) begin
      ref_d       = sync_s;
      stall_cnt_d = '0;
    end else if (stall_cnt_q != 8'(TIMEOUT)) begin
      stall_cnt_d = stall_cnt_q + 8'd1;
    end
  end

  always_comb begin
    state_d     = state_q;
    step_cnt_d  = step_cnt_q;
    bit_time_d  = bit_time_q;
    phase_d     = cur_ph;
    phase_stb_d = 1'b0;
    bit_stb_d   = 1'b0;
    syl_stb_d   = 1'b0;
    seq_err_d   = 1'b0;
    case (state_q)
      ST_HUNT: begin
        if (legal) begin
          step_cnt_d = 4'd1;
          if (LOCK_COUNT == 1) begin
            state_d    = ST_LOCKED;
            bit_time_d = '0;
          end else begin
            state_d = ST_VERIFY;
          end
        end
      end
      ST_VERIFY: begin
        if (illegal || stall) begin
          seq_err_d = 1'b1;
          state_d   = ST_HUNT;
        end else if (legal) begin
          step_cnt_d = step_cnt_q + 4'd1;
          if (step_cnt_q + 4'd1 == 4'(LOCK_COUNT)) begin
            state_d    = ST_LOCKED;
            bit_time_d = '0;
          end
        end
      end
      ST_LOCKED: begin
        if (illegal || stall) begin
          seq_err_d  = 1'b1;
          state_d    = ST_HUNT;
          bit_time_d = '0;
        end else if (legal) begin
          phase_stb_d = 1'b1;
          if (wrap_step) begin
            bit_stb_d = 1'b1;
            if (bit_time_q == 4'(BITS_PER_SYL - 1)) begin
              bit_time_d = '0;
              syl_stb_d  = 1'b1;
            end else begin
              bit_time_d = bit_time_q + 4'd1;
            end
          end
        end
      end
      default: state_d = ST_HUNT;
    endcase
  end

  // A clear coinciding with a new error leaves that error counted.
  always_comb begin
    err_cnt_d = err_cnt_q;
    if (ERR_CLR) begin
      err_cnt_d = {7'd0, seq_err_d};
    end else if (seq_err_d && (err_cnt_q != 8'hFF)) begin
      err_cnt_d = err_cnt_q + 8'd1;
    end
  end

  always_ff @(posedge CLK or negedge RSTN) begin
    if (!RSTN) begin
      state_q     <= ST_HUNT;
      prime_cnt_q <= '0;
      primed_q    <= 1'b0;
      ref_valid_q <= 1'b0;
      ref_q       <= '0;
      stall_cnt_q <= '0;
      step_cnt_q  <= '0;
      bit_time_q  <= '0;
      phase_q     <= '0;
      phase_stb_q <= 1'b0;
      bit_stb_q   <= 1'b0;
      syl_stb_q   <= 1'b0;
      seq_err_q   <= 1'b0;
      err_cnt_q   <= '0;
    end else begin
      state_q     <= state_d;
      prime_cnt_q <= prime_cnt_d;
      primed_q    <= primed_d;
      ref_valid_q <= ref_valid_d;
      ref_q       <= ref_d;
      stall_cnt_q <= stall_cnt_d;
      step_cnt_q  <= step_cnt_d;
      bit_time_q  <= bit_time_d;
      phase_q     <= phase_d;
      phase_stb_q <= phase_stb_d;
      bit_stb_q   <= bit_stb_d;
      syl_stb_q   <= syl_stb_d;
      seq_err_q   <= seq_err_d;
      err_cnt_q   <= err_cnt_d;
    end
  end

  assign PHASE     = phase_q;
  assign PHASE_STB = phase_stb_q;
  assign BIT_TIME  = bit_time_q;
  assign BIT_STB   = bit_stb_q;
  assign SYL_STB   = syl_stb_q;
  assign LOCKED    = (state_q == ST_LOCKED);
  assign SEQ_ERR   = seq_err_q;
  assign ERR_CNT   = err_cnt_q;

endmodule

// File: tb/tb_clock_phase_decoder.sv
// Directed bench for clock_phase_decoder: a table of lock-up steps plus hand-written
// sequences for bit/syllable wrap, illegal steps, stalls, error saturation and reset.
module tb_clock_phase_decoder;

  logic       CLK = 1'b0;
  logic       RSTN = 1'b0;
  logic       PI = 1'b0, QI = 1'b0, RI = 1'b0, ERR_CLR = 1'b0;
  logic [1:0] PHASE;
  logic       PHASE_STB, BIT_STB, SYL_STB, LOCKED, SEQ_ERR;
  logic [3:0] BIT_TIME;
  logic [7:0] ERR_CNT;

  clock_phase_decoder #(
    .BITS_PER_SYL(14), .LOCK_COUNT(4), .SYNC_STAGES(2), .TIMEOUT(64)
  ) dut (
    .CLK(CLK), .RSTN(RSTN), .PI(PI), .QI(QI), .RI(RI), .ERR_CLR(ERR_CLR),
    .PHASE(PHASE), .PHASE_STB(PHASE_STB), .BIT_TIME(BIT_TIME), .BIT_STB(BIT_STB),
    .SYL_STB(SYL_STB), .LOCKED(LOCKED), .SEQ_ERR(SEQ_ERR), .ERR_CNT(ERR_CNT)
  );

  always #5 CLK = ~CLK;

  typedef struct {
    logic [1:0] ph;
    logic       r;
    logic [1:0] e_phase;
    logic       e_pstb;
    logic       e_bstb;
    logic [3:0] e_bt;
    logic       e_lock;
  } vec_t;

  int checks = 0;
  int failures = 0;
  int n_err = 0, n_bit = 0, n_syl = 0, n_pstb = 0;
  logic       cur_r = 1'b0;
  logic       pre_err;
  logic [1:0] s_phase;
  logic       s_pstb, s_bstb, s_sstb, s_lock, s_err;
  logic [3:0] s_bt;
  logic [7:0] s_cnt;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got %0d expected %0d", name, act, exp);
    end
  endtask

  task automatic tick();
    @(negedge CLK);
    if (SEQ_ERR)   n_err++;
    if (BIT_STB)   n_bit++;
    if (SYL_STB)   n_syl++;
    if (PHASE_STB) n_pstb++;
  endtask

  // Drive a phase, capture outputs at the synchronizer+register latency (3 cycles).
  task automatic step_to(input logic [1:0] ph, input logic r, input int hold);
    PI = (ph == 2'd1) || (ph == 2'd2);
    QI = (ph == 2'd2) || (ph == 2'd3);
    RI = r;
    cur_r = r;
    tick();
    tick();
    pre_err = SEQ_ERR;
    tick();
    s_phase = PHASE; s_pstb = PHASE_STB; s_bstb = BIT_STB; s_sstb = SYL_STB;
    s_bt = BIT_TIME; s_lock = LOCKED; s_err = SEQ_ERR; s_cnt = ERR_CNT;
    $display("step ph=%0d r=%0d -> PHASE=%0d PSTB=%0d BSTB=%0d SSTB=%0d BT=%0d LOCK=%0d ERR=%0d CNT=%0d",
             ph, r, s_phase, s_pstb, s_bstb, s_sstb, s_bt, s_lock, s_err, s_cnt);
    for (int i = 3; i < hold; i++) tick();
  endtask

  // Four legal steps from phase 0 ending back at phase 0.
  task automatic bit_cycle(input int hold);
    step_to(2'd1, cur_r, hold);
    step_to(2'd2, cur_r, hold);
    step_to(2'd3, cur_r, hold);
    step_to(2'd0, ~cur_r, hold);
  endtask

  initial begin
    vec_t vt[12];
    int   e0, b0, y0, p0;
    int   exp_bt;

    vt[0]  = '{2'd1, 1'b0, 2'd1, 1'b0, 1'b0, 4'd0, 1'b0};
    vt[1]  = '{2'd2, 1'b0, 2'd2, 1'b0, 1'b0, 4'd0, 1'b0};
    vt[2]  = '{2'd3, 1'b0, 2'd3, 1'b0, 1'b0, 4'd0, 1'b0};
    vt[3]  = '{2'd0, 1'b1, 2'd0, 1'b0, 1'b0, 4'd0, 1'b1};
    vt[4]  = '{2'd1, 1'b1, 2'd1, 1'b1, 1'b0, 4'd0, 1'b1};
    vt[5]  = '{2'd2, 1'b1, 2'd2, 1'b1, 1'b0, 4'd0, 1'b1};
    vt[6]  = '{2'd3, 1'b1, 2'd3, 1'b1, 1'b0, 4'd0, 1'b1};
    vt[7]  = '{2'd0, 1'b0, 2'd0, 1'b1, 1'b1, 4'd1, 1'b1};
    vt[8]  = '{2'd1, 1'b0, 2'd1, 1'b1, 1'b0, 4'd1, 1'b1};
    vt[9]  = '{2'd2, 1'b0, 2'd2, 1'b1, 1'b0, 4'd1, 1'b1};
    vt[10] = '{2'd3, 1'b0, 2'd3, 1'b1, 1'b0, 4'd1, 1'b1};
    vt[11] = '{2'd0, 1'b1, 2'd0, 1'b1, 1'b1, 4'd2, 1'b1};

    // Reset state
    repeat (3) tick();
    chk("rst_phase", PHASE, 0);
    chk("rst_pstb", PHASE_STB, 0);
    chk("rst_bt", BIT_TIME, 0);
    chk("rst_bstb", BIT_STB, 0);
    chk("rst_sstb", SYL_STB, 0);
    chk("rst_lock", LOCKED, 0);
    chk("rst_err", SEQ_ERR, 0);
    chk("rst_cnt", ERR_CNT, 0);
    RSTN = 1'b1;
    repeat (6) tick();

    // Lock-up table: 12 legal steps, 8 cycles per phase
    e0 = n_err;
    for (int k = 0; k < 12; k++) begin
      step_to(vt[k].ph, vt[k].r, 8);
      chk($sformatf("tbl%0d_phase", k), s_phase, vt[k].e_phase);
      chk($sformatf("tbl%0d_pstb", k), s_pstb, vt[k].e_pstb);
      chk($sformatf("tbl%0d_bstb", k), s_bstb, vt[k].e_bstb);
      chk($sformatf("tbl%0d_bt", k), s_bt, vt[k].e_bt);
      chk($sformatf("tbl%0d_lock", k), s_lock, vt[k].e_lock);
    end
    chk("tbl_no_seq_err", n_err - e0, 0);

    // Two full syllables of bit times
    exp_bt = 2;
    b0 = n_bit; y0 = n_syl; p0 = n_pstb;
    for (int k = 0; k < 28; k++) begin
      bit_cycle(4);
      exp_bt = (exp_bt + 1) % 14;
      chk("syl_bstb", s_bstb, 1);
      chk("syl_bt", s_bt, exp_bt);
      chk("syl_sstb", s_sstb, (exp_bt == 0) ? 1 : 0);
    end
    chk("syl_bit_pulses", n_bit - b0, 28);
    chk("syl_syl_pulses", n_syl - y0, 2);
    chk("syl_phase_pulses", n_pstb - p0, 112);

    // Two-bit jump 00 -> 11 while locked, then relock
    e0 = n_err;
    step_to(2'd2, cur_r, 8);
    chk("jump_pre_err", pre_err, 0);
    chk("jump_err", s_err, 1);
    chk("jump_lock", s_lock, 0);
    chk("jump_bt", s_bt, 0);
    chk("jump_cnt", s_cnt, 1);
    chk("jump_phase", s_phase, 2);
    chk("jump_one_pulse", n_err - e0, 1);
    step_to(2'd3, cur_r, 8);
    step_to(2'd0, ~cur_r, 8);
    step_to(2'd1, cur_r, 8);
    chk("relock3_lock", s_lock, 0);
    step_to(2'd2, cur_r, 8);
    chk("relock4_lock", s_lock, 1);
    chk("relock4_pstb", s_pstb, 0);

    // 3->0 without R toggle, then a long static hold in HUNT
    step_to(2'd3, cur_r, 8);
    chk("nort_pre_pstb", s_pstb, 1);
    step_to(2'd0, cur_r, 8);
    chk("nort_err", s_err, 1);
    chk("nort_lock", s_lock, 0);
    chk("nort_cnt", s_cnt, 2);
    e0 = n_err;
    repeat (100) tick();
    chk("hunt_static_no_err", n_err - e0, 0);

    // Stall while locked: SEQ_ERR exactly 64 cycles after the last change
    step_to(2'd1, cur_r, 4);
    step_to(2'd2, cur_r, 4);
    step_to(2'd3, cur_r, 4);
    step_to(2'd0, ~cur_r, 3);
    chk("stall_locked", s_lock, 1);
    repeat (63) tick();
    chk("stall_63_err", SEQ_ERR, 0);
    chk("stall_63_lock", LOCKED, 1);
    tick();
    chk("stall_64_err", SEQ_ERR, 1);
    chk("stall_64_lock", LOCKED, 0);
    chk("stall_64_cnt", ERR_CNT, 3);

    // 300 errors: legal step into VERIFY, then a backward step
    e0 = n_err;
    for (int k = 0; k < 300; k++) begin
      step_to(2'd1, cur_r, 4);
      step_to(2'd0, cur_r, 4);
    end
    chk("sat_pulses", n_err - e0, 300);
    chk("sat_cnt", ERR_CNT, 255);
    ERR_CLR = 1'b1;
    tick();
    ERR_CLR = 1'b0;
    chk("clr_cnt", ERR_CNT, 0);
    for (int k = 0; k < 2; k++) begin
      step_to(2'd1, cur_r, 4);
      step_to(2'd0, cur_r, 4);
    end
    chk("two_err_cnt", ERR_CNT, 2);
    step_to(2'd1, cur_r, 4);
    PI = 1'b0; QI = 1'b0;
    tick();
    tick();
    ERR_CLR = 1'b1;
    tick();
    ERR_CLR = 1'b0;
    chk("clr_coinc_err", SEQ_ERR, 1);
    chk("clr_coinc_cnt", ERR_CNT, 1);
    repeat (4) tick();

    // Asynchronous reset mid-syllable
    bit_cycle(4);
    bit_cycle(4);
    step_to(2'd1, cur_r, 4);
    chk("pre_rst_lock", s_lock, 1);
    chk("pre_rst_bt", s_bt, 1);
    chk("pre_rst_phase", s_phase, 1);
    chk("pre_rst_cnt", s_cnt, 1);
    #2 RSTN = 1'b0;
    #1;
    chk("arst_phase", PHASE, 0);
    chk("arst_bt", BIT_TIME, 0);
    chk("arst_lock", LOCKED, 0);
    chk("arst_cnt", ERR_CNT, 0);
    chk("arst_err", SEQ_ERR, 0);
    chk("arst_pstb", PHASE_STB, 0);
    @(negedge CLK);
    RSTN = 1'b1;
    e0 = n_err;
    repeat (6) tick();
    chk("post_rst_phase", PHASE, 1);
    chk("post_rst_no_err", n_err - e0, 0);
    step_to(2'd2, cur_r, 4);
    step_to(2'd3, cur_r, 4);
    step_to(2'd0, ~cur_r, 4);
    chk("first_sample_3_lock", s_lock, 0);
    step_to(2'd1, cur_r, 4);
    chk("first_sample_4_lock", s_lock, 1);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/clock_phase_decoder.md
# clock_phase_decoder

Receive-side counterpart to the triple-redundant clock divider: it takes one channel's phase-flop outputs (P, Q, R level signals, asynchronous to the local clock) and synchronizes them. It verifies that they step through the legal phase sequence, and regenerates phase, bit-time and syllable strobes for downstream logic on a single system clock. It also maintains lock status and a saturating sequence-error count used by the redundancy monitor.

## Interface
- BITS_PER_SYL, 14, bit times per syllable (2..16)
- LOCK_COUNT, 4, consecutive legal phase steps required to declare lock (1..15)
- SYNC_STAGES, 2, synchronizer depth for P/Q/R (2..3)
- TIMEOUT, 64, CLK cycles without any input change before a stall error (8..255)

Ports:
- CLK  in  1  system clock
- RSTN  in  1  reset, asynchronous, active-low
- PI  in  1  divider P flop level (async)
- QI  in  1  divider Q flop level (async)
- RI  in  1  divider R flop level (async), bit-time parity
- ERR_CLR  in  1  synchronous clear of ERR_CNT
- PHASE  out  2  decoded current phase, 0..3
- PHASE_STB  out  1  one-cycle pulse on each legal phase step while locked
- BIT_TIME  out  4  current bit time, 0..BITS_PER_SYL-1
- BIT_STB  out  1  one-cycle pulse on each 3->0 phase step while locked
- SYL_STB  out  1  one-cycle pulse when BIT_TIME wraps to 0
- LOCKED  out  1  state == LOCKED
- SEQ_ERR  out  1  one-cycle pulse on any detected sequence or stall error
- ERR_CNT  out  8  saturating error count

## Operation
- PI/QI/RI each pass through a SYNC_STAGES flop synchronizer, reset to 0.
- Phase code {P,Q}: 00->0, 10->1, 11->2, 01->3. A legal step is exactly one of 0->1, 1->2, 2->3, 3->0.
- R must be unchanged on steps 0->1, 1->2 and 2->3, and must toggle on 3->0.
- Any other change is illegal. This includes a backward step, a two-bit {P,Q} jump, an R change on a non-wrap step, and a 3->0 step without an R toggle. A cycle with no change is neither legal nor illegal.
- First-sample rule: the first synchronized sample after reset is loaded as the reference without evaluation. This is gated by a primed flag set SYNC_STAGES cycles after reset release.
- State machine has three states:
  - HUNT: a legal step goes to VERIFY with step count 1. Illegal changes are ignored, with no SEQ_ERR.
  - VERIFY: a legal step increments the step count. When the count reaches LOCK_COUNT, go to LOCKED. An illegal change or a stall pulses SEQ_ERR and returns to HUNT.
  - LOCKED: a legal step pulses PHASE_STB. An illegal change or a stall pulses SEQ_ERR, returns to HUNT and clears BIT_TIME to 0.
- BIT_TIME rules:
  - Forced to 0 on entry to LOCKED.
  - In LOCKED, each 3->0 step pulses BIT_STB and increments BIT_TIME modulo BITS_PER_SYL.
  - The wrap from BITS_PER_SYL-1 to 0 also pulses SYL_STB in the same cycle.
- Stall counter: counts CLK cycles since the last synchronized input change. It saturates at TIMEOUT and is reset on every change.
  - Reaching TIMEOUT in VERIFY or LOCKED is a stall.
  - In HUNT the stall counter is never flagged.
- ERR_CNT increments on each SEQ_ERR and saturates at 255.
  - ERR_CLR sets it to 0.
  - If ERR_CLR and SEQ_ERR occur in the same cycle, the result is 1.
- PHASE always tracks the decoded synchronized {P,Q}, including in HUNT and VERIFY.

## Timing
- Reset values: PHASE=0, PHASE_STB=0, BIT_TIME=0, BIT_STB=0, SYL_STB=0, LOCKED=0, SEQ_ERR=0, ERR_CNT=0. State is HUNT and all synchronizer, reference and counter flops are 0.
- RSTN assertion mid-operation clears everything immediately (asynchronous). Release is sampled on a CLK rising edge.
- Latency from an input edge to the corresponding PHASE, PHASE_STB, BIT_STB, SYL_STB, SEQ_ERR or LOCKED update is SYNC_STAGES+1 CLK cycles. All outputs are registered.
- LOCKED rises in the same cycle the LOCK_COUNT-th legal step is registered. That step produces no PHASE_STB.
- A stall SEQ_ERR fires exactly TIMEOUT cycles after the last registered change.
- Input constraint: each input level is held at least 3 CLK cycles. Faster inputs are out of spec, and their detection as illegal jumps is acceptable.

## Test plan
- Reset, then drive 12 legal steps with 8 CLK cycles per phase (defaults) -> LOCKED=1 at step 4. PHASE_STB pulses for steps 5..12. BIT_STB pulses on each 3->0 step once locked. SEQ_ERR never pulses.
- Locked, run 2×14 bit times -> BIT_TIME counts 0..13 then 0. SYL_STB coincides with BIT_STB exactly at each 13->0 wrap, twice.
- Locked, force {P,Q} 00->11 -> SEQ_ERR one pulse at SYNC_STAGES+1 cycles, LOCKED=0, BIT_TIME=0, ERR_CNT=1. Four further legal steps relock.
- Locked, 3->0 step without an R toggle -> SEQ_ERR and a return to HUNT. Then hold the inputs static for 100 cycles in HUNT -> no further SEQ_ERR.
- Locked, hold the inputs static -> SEQ_ERR exactly 64 cycles after the last change, LOCKED=0.
- Inject 300 errors -> ERR_CNT saturates at 255. ERR_CLR coincident with SEQ_ERR -> ERR_CNT=1. Assert RSTN low mid-syllable -> all outputs return to 0 immediately.
